// File: rtl/player_motion_ctrl_if.sv
// Player motion control bus: frame/start/gravity/line inputs in, position and status out.
interface player_motion_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       dir;
    logic [2:0] lines;
    logic [8:0] height;
    logic       grounded;
    logic       is_dead;
    logic [1:0] state;

    // Driver side (game logic / testbench)
    modport master (
        output frame_tick, start, dir, lines,
        input  height, grounded, is_dead, state
    );

    // Motion controller side
    modport slave (
        input  frame_tick, start, dir, lines,
        output height, grounded, is_dead, state
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player vertical motion sequencer for the gravity-flip game.
// Moves the player one STEP per frame tick toward the active gravity direction,
// lands on rest points whose line is present and declares death at the screen edges.
module player_motion_ctrl #(
    parameter int unsigned STEP    = 4,
    parameter int unsigned START_H = 120,
    parameter int unsigned TOP_H   = 0,
    parameter int unsigned BOT_H   = 476
) (
    input  logic                 clk,
    input  logic                 reset,
    player_motion_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StGrounded = 2'b01,
        StFalling  = 2'b10,
        StDead     = 2'b11
    } state_e;

    localparam logic [9:0] StepW   = 10'(STEP);
    localparam logic [9:0] StartW  = 10'(START_H);
    localparam logic [9:0] TopW    = 10'(TOP_H);
    localparam logic [9:0] BotW    = 10'(BOT_H);
    localparam logic [9:0] RestD0  = 10'd120;  // dir=0, needs lines[0]
    localparam logic [9:0] RestD1  = 10'd240;  // dir=0, needs lines[1]
    localparam logic [9:0] RestU0  = 10'd180;  // dir=1, needs lines[1]
    localparam logic [9:0] RestU1  = 10'd300;  // dir=1, needs lines[2]

    state_e     state_q, state_d;
    logic [9:0] height_q, height_d;
    logic       grounded_q, is_dead_q;
    logic [9:0] nxt_down, nxt_up;

    // A height is a valid resting place only for its own gravity direction and present line.
    function automatic logic rest_ok(input logic [9:0] h, input logic d, input logic [2:0] ln);
        logic ok;
        ok = 1'b0;
        if (!d) begin
            ok = (h == RestD0 && ln[0]) || (h == RestD1 && ln[1]);
        end else begin
            ok = (h == RestU0 && ln[1]) || (h == RestU1 && ln[2]);
        end
        return ok;
    endfunction

    // Next-state and next-height decode.
    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        nxt_down = height_q + StepW;
        nxt_up   = height_q - StepW;
        unique case (state_q)
            StIdle, StDead: begin
                if (bus.start) begin
                    height_d = StartW;
                    state_d  = rest_ok(StartW, bus.dir, bus.lines) ? StGrounded : StFalling;
                end
            end
            StGrounded: begin
                // Losing the line or flipping gravity drops the player; motion waits for a tick.
                if (!rest_ok(height_q, bus.dir, bus.lines)) begin
                    state_d = StFalling;
                end
            end
            StFalling: begin
                if (bus.frame_tick) begin
                    if (!bus.dir) begin
                        if (bus.lines[0] && height_q < RestD0 && nxt_down >= RestD0) begin
                            height_d = RestD0;
                            state_d  = StGrounded;
                        end else if (bus.lines[1] && height_q < RestD1 && nxt_down >= RestD1) begin
                            height_d = RestD1;
                            state_d  = StGrounded;
                        end else if (nxt_down >= BotW) begin
                            height_d = BotW;
                            state_d  = StDead;
                        end else begin
                            height_d = nxt_down;
                        end
                    end else begin
                        // Rest points are far above STEP, so nxt_up never wraps in these tests.
                        if (bus.lines[1] && height_q > RestU0 && nxt_up <= RestU0) begin
                            height_d = RestU0;
                            state_d  = StGrounded;
                        end else if (bus.lines[2] && height_q > RestU1 && nxt_up <= RestU1) begin
                            height_d = RestU1;
                            state_d  = StGrounded;
                        end else if (height_q <= TopW + StepW) begin
                            height_d = TopW;
                            state_d  = StDead;
                        end else begin
                            height_d = nxt_up;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, position and status flags, all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            height_q   <= StartW;
            grounded_q <= 1'b0;
            is_dead_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            grounded_q <= (state_d == StGrounded);
            is_dead_q  <= (state_d == StDead);
        end
    end

    assign bus.height   = height_q[8:0];
    assign bus.grounded = grounded_q;
    assign bus.is_dead  = is_dead_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios with literal expectations plus
// randomized play, all checked against a rest-point-table model every cycle.
module tb_player_motion_ctrl;

    localparam int STEP    = 4;
    localparam int START_H = 120;
    localparam int TOP_H   = 0;
    localparam int BOT_H   = 476;

    logic clk;
    logic reset;
    player_motion_ctrl_if bus ();

    player_motion_ctrl #(
        .STEP    (STEP),
        .START_H (START_H),
        .TOP_H   (TOP_H),
        .BOT_H   (BOT_H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 grounded, 2 falling, 3 dead.
    typedef struct packed {
        int h;
        int st;
    } mstate_t;

    int rp_h[4] = '{120, 240, 180, 300};
    int rp_d[4] = '{0, 0, 1, 1};
    int rp_l[4] = '{0, 1, 1, 2};

    mstate_t m;

    function automatic bit rest_valid(input int h, input bit d, input logic [2:0] ln);
        for (int i = 0; i < 4; i++) begin
            if (rp_h[i] == h && rp_d[i] == int'(d) && ln[rp_l[i]]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic mstate_t step(input mstate_t cur, input bit st_p, input bit tk,
                                     input bit d, input logic [2:0] ln);
        mstate_t n;
        int nxt;
        bit landed;
        n = cur;
        case (cur.st)
            0, 3: if (st_p) begin
                n.h  = START_H;
                n.st = rest_valid(START_H, d, ln) ? 1 : 2;
            end
            1: if (!rest_valid(cur.h, d, ln)) n.st = 2;
            2: if (tk) begin
                nxt    = d ? cur.h - STEP : cur.h + STEP;
                landed = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!landed && rp_d[i] == int'(d) && ln[rp_l[i]] &&
                        (d ? (cur.h > rp_h[i] && rp_h[i] >= nxt)
                           : (cur.h < rp_h[i] && rp_h[i] <= nxt))) begin
                        n.h    = rp_h[i];
                        n.st   = 1;
                        landed = 1'b1;
                    end
                end
                if (!landed) begin
                    if (!d && nxt >= BOT_H) begin
                        n.h = BOT_H; n.st = 3;
                    end else if (d && cur.h <= TOP_H + STEP) begin
                        n.h = TOP_H; n.st = 3;
                    end else begin
                        n.h = nxt;
                    end
                end
            end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{h: START_H, st: 0};
        else m <= step(m, bus.start, bus.frame_tick, bus.dir, bus.lines);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model.height", int'(bus.height), m.h);
            check("model.state", int'(bus.state), m.st);
            check("model.grounded", int'(bus.grounded), int'(m.st == 1));
            check("model.is_dead", int'(bus.is_dead), int'(m.st == 3));
        end
    end

    // ---------------- stimulus helpers (entered and left at a negedge) ----------------
    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    int n_tk;

    initial begin
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.dir        = 1'b0;
        bus.lines      = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // 1: reset state, then start onto line 0 and sit still
        check("reset.state", int'(bus.state), 0);
        check("reset.height", int'(bus.height), 120);
        check("reset.grounded", int'(bus.grounded), 0);
        check("reset.is_dead", int'(bus.is_dead), 0);
        bus.lines = 3'b001;
        bus.dir   = 1'b0;
        pulse_start();
        check("s1.state", int'(bus.state), 1);
        check("s1.grounded", int'(bus.grounded), 1);
        ticks(10);
        check("s1.height_held", int'(bus.height), 120);

        // 2: line 0 removed, fall down onto line 1 at 240
        bus.lines = 3'b000;
        @(negedge clk);
        check("s2.falling", int'(bus.state), 2);
        bus.lines = 3'b010;
        tick();
        check("s2.first_step", int'(bus.height), 124);
        ticks(28);
        check("s2.tick29", int'(bus.height), 236);
        tick();
        check("s2.land_h", int'(bus.height), 240);
        check("s2.land_grounded", int'(bus.grounded), 1);

        // 3: gravity flips up, land on 180
        bus.dir = 1'b1;
        @(negedge clk);
        check("s3.falling", int'(bus.state), 2);
        ticks(14);
        check("s3.tick14", int'(bus.height), 184);
        tick();
        check("s3.land_h", int'(bus.height), 180);
        check("s3.land_state", int'(bus.state), 1);

        // 4: fall off the bottom from 120
        do_reset();
        bus.lines = 3'b000;
        bus.dir   = 1'b0;
        pulse_start();
        check("s4.start_h", int'(bus.height), 120);
        n_tk = 0;
        while (!bus.is_dead && n_tk < 120) begin
            tick();
            n_tk++;
        end
        check("s4.ticks_to_death", n_tk, 89);
        check("s4.dead_h", int'(bus.height), 476);
        check("s4.dead_state", int'(bus.state), 3);
        bus.dir   = 1'b1;
        bus.lines = 3'b111;
        ticks(3);
        check("s4.dead_held_h", int'(bus.height), 476);
        check("s4.dead_held_st", int'(bus.state), 3);
        bus.dir   = 1'b0;
        bus.lines = 3'b000;
        pulse_start();
        check("s4.restart_h", int'(bus.height), 120);
        check("s4.restart_st", int'(bus.state), 2);

        // 5: fall off the top, no wrap
        bus.dir = 1'b1;
        ticks(29);
        check("s5.tick29", int'(bus.height), 4);
        tick();
        check("s5.top_h", int'(bus.height), 0);
        check("s5.top_state", int'(bus.state), 3);

        // 6: asynchronous reset mid-fall
        bus.dir = 1'b0;
        pulse_start();
        ticks(20);
        check("s6.pre_reset_h", int'(bus.height), 200);
        #2 reset = 1'b0;
        #1;
        check("s6.rst_h", int'(bus.height), 120);
        check("s6.rst_state", int'(bus.state), 0);
        check("s6.rst_grounded", int'(bus.grounded), 0);
        check("s6.rst_dead", int'(bus.is_dead), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Randomized play
        for (int c = 0; c < 4000; c++) begin
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.start      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 9) == 0) bus.lines = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
